// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// operand-compare helpers.
package pipe_hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        ERROR    = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use hazard detector: flags an ID source operand that matches the
// destination of a load currently in EX.
module hazard_cmp
    import pipe_hazard_pkg::*;
(
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_rd_i,
    input  logic [REG_W-1:0] ex_rt_i,
    output logic             lu_hit_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign lu_hit_o = ex_mem_rd_i & (ex_rt_i != ZERO_REG) & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// PC / IF-ID sequencing for the 5-stage core: load-use stalls, branch flushes,
// memory freezes and a memory-stall watchdog. Optional perf counters: PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int LU_CYCLES = 1,
    parameter int MAX_WAIT  = 256,
    parameter int WAIT_W    = 9,
    parameter int PERF_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_rd_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             br_taken_i,
    input  logic             mem_stall_i,
    output logic             pc_wr_o,
    output logic             if_id_wr_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             wd_err_o,
    output logic [1:0]       state_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] lu_stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o,
    output logic [PERF_W-1:0] mem_wait_cnt_o
`endif
);

    localparam bit               WD_EN   = (MAX_WAIT != 0);
    localparam logic [WAIT_W-1:0] WD_LAST = WD_EN ? WAIT_W'(MAX_WAIT - 1) : '0;
    // First LU_STALL cycle follows the RUN cycle that saw the hit
    localparam logic [1:0]        LU_INIT = (LU_CYCLES > 1) ? 2'(LU_CYCLES - 2) : 2'd0;

    state_e            state_q, state_d;
    logic [1:0]        lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic lu_hit;
    logic stall;
    logic frozen;

    hazard_cmp u_hazard_cmp (
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .ex_mem_rd_i  (ex_mem_rd_i),
        .ex_rt_i      (ex_rt_i),
        .lu_hit_o     (lu_hit)
    );

    assign stall  = (state_q == LU_STALL) | ((state_q == RUN) & lu_hit);
    assign frozen = (state_q == ERROR) | mem_stall_i;

    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = '0;

        if (mem_stall_i) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        if (state_q != ERROR) begin
            if (WD_EN && mem_stall_i && (wait_cnt_q == WD_LAST)) begin
                state_d = ERROR;
            end else if (!mem_stall_i) begin
                if (state_q == LU_STALL) begin
                    if (lu_cnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        lu_cnt_d = lu_cnt_q - 2'd1;
                    end
                end else if (lu_hit && (LU_CYCLES > 1)) begin
                    state_d  = LU_STALL;
                    lu_cnt_d = LU_INIT;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= RUN;
            lu_cnt_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        pc_wr_o        = 1'b1;
        if_id_wr_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_freeze_o  = 1'b0;

        if (!rst_i) begin
            pc_wr_o        = 1'b0;
            if_id_wr_o     = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (frozen) begin
            pc_wr_o       = 1'b0;
            if_id_wr_o    = 1'b0;
            pipe_freeze_o = 1'b1;
        end else if (stall) begin
            // A branch seen here is dropped; ID re-resolves it once the stall ends
            pc_wr_o        = 1'b0;
            if_id_wr_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (br_taken_i) begin
            if_id_flush_o = 1'b1;
        end
    end

    assign wd_err_o = (state_q == ERROR);
    assign state_o  = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [2:0]             perf_evt;
    logic [PERF_W-1:0]      perf_q [3];
    logic [PERF_W-1:0]      perf_d [3];

    assign perf_evt[0] = rst_i & ~frozen & stall;
    assign perf_evt[1] = rst_i & ~frozen & ~stall & br_taken_i;
    assign perf_evt[2] = rst_i & frozen;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            always_comb begin
                perf_d[gi] = perf_q[gi];
                if (perf_evt[gi] && (perf_q[gi] != '1)) begin
                    perf_d[gi] = perf_q[gi] + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    perf_q[gi] <= '0;
                end else begin
                    perf_q[gi] <= perf_d[gi];
                end
            end
        end
    endgenerate

    assign lu_stall_cnt_o = perf_q[0];
    assign flush_cnt_o    = perf_q[1];
    assign mem_wait_cnt_o = perf_q[2];
`endif

endmodule
